// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: single-entry issue buffer between fetch and decode/execute.
// Tracks in-flight register writes in a 32-bit scoreboard and stalls the held
// instruction on RAW/WAW hazards until writeback retires the register. A
// same-cycle writeback is bypassed so it releases the stall immediately.
module decode_issue_ctrl #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid_i,
  input  logic [DWIDTH-1:0] fetch_insn_i,
  input  logic [AWIDTH-1:0] fetch_pc_i,
  output logic              fetch_ready_o,
  output logic              issue_valid_o,
  output logic [DWIDTH-1:0] issue_insn_o,
  output logic [AWIDTH-1:0] issue_pc_o,
  input  logic              issue_ready_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       busy_mask_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);

  logic              hold_valid_q;
  logic [DWIDTH-1:0] hold_insn_q;
  logic [AWIDTH-1:0] hold_pc_q;
  logic [31:0]       busy_q;
  logic [31:0]       busy_d;

  logic [6:0]  opcode_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  logic        uses_rs1_s;
  logic        uses_rs2_s;
  logic        writes_rd_s;
  logic [31:0] wb_clear_s;
  logic [31:0] eff_busy_s;
  logic        hazard_s;
  logic        fire_s;
  logic        accept_s;

  assign opcode_s = hold_insn_q[6:0];
  assign rs1_s    = hold_insn_q[19:15];
  assign rs2_s    = hold_insn_q[24:20];
  assign rd_s     = hold_insn_q[11:7];

  // Decode which register fields the held opcode reads and writes.
  always_comb begin
    uses_rs1_s  = 1'b0;
    uses_rs2_s  = 1'b0;
    writes_rd_s = 1'b0;
    case (opcode_s)
      OP_R:      begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; writes_rd_s = 1'b1; end
      OP_IMM:    begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
      OP_LOAD:   begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
      OP_STORE:  begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
      OP_BRANCH: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
      OP_JALR:   begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
      OP_JAL:    begin writes_rd_s = 1'b1; end
      OP_LUI:    begin writes_rd_s = 1'b1; end
      OP_AUIPC:  begin writes_rd_s = 1'b1; end
      default:   begin uses_rs1_s = 1'b0; uses_rs2_s = 1'b0; writes_rd_s = 1'b0; end
    endcase
  end

  // Bypass a same-cycle writeback out of the scoreboard; x0 is never busy.
  always_comb begin
    if (wb_valid_i) begin
      wb_clear_s = 32'd1 << wb_rd_i;
    end else begin
      wb_clear_s = 32'd0;
    end
    eff_busy_s    = busy_q & ~wb_clear_s;
    eff_busy_s[0] = 1'b0;
  end

  // Hazard check of the held instruction against the bypassed scoreboard.
  always_comb begin
    hazard_s = 1'b0;
    if (hold_valid_q) begin
      hazard_s = (uses_rs1_s && eff_busy_s[rs1_s]) ||
                 (uses_rs2_s && eff_busy_s[rs2_s]) ||
                 (writes_rd_s && (rd_s != 5'd0) && eff_busy_s[rd_s]);
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign issue_valid_o = hold_valid_q & ~hazard_s;
  assign stall_o       = hold_valid_q & hazard_s;
  assign fire_s        = issue_valid_o & issue_ready_i;
  assign fetch_ready_o = ~flush_i & (~hold_valid_q | fire_s);
  assign accept_s      = fetch_valid_i & fetch_ready_o;
  assign issue_insn_o  = hold_insn_q;
  assign issue_pc_o    = hold_pc_q;
  assign busy_mask_o   = busy_q;

  // Next scoreboard: retire writebacks, then mark the issuing writer (set wins).
  always_comb begin
    busy_d = eff_busy_s;
    if (fire_s && writes_rd_s && (rd_s != 5'd0)) begin
      busy_d[rd_s] = 1'b1;
    end else begin
      busy_d = eff_busy_s;
    end
  end

  // Hold register and scoreboard state; flush empties the hold but keeps busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_insn_q  <= NOP_INSN;
      hold_pc_q    <= BASEADDR;
      busy_q       <= 32'd0;
    end else begin
      busy_q <= busy_d;
      if (flush_i) begin
        hold_valid_q <= 1'b0;
      end else if (accept_s) begin
        hold_valid_q <= 1'b1;
        hold_insn_q  <= fetch_insn_i;
        hold_pc_q    <= fetch_pc_i;
      end else if (fire_s) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Testbench for decode_issue_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural scoreboard model.
module tb_decode_issue_ctrl;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_insn_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_ready_o;
  logic        issue_valid_o;
  logic [31:0] issue_insn_o;
  logic [31:0] issue_pc_o;
  logic        issue_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] busy_mask_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  bit          m_hold;
  logic [31:0] m_insn;
  logic [31:0] m_pc;
  bit          m_busy [32];

  decode_issue_ctrl #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_i(fetch_valid_i), .fetch_insn_i(fetch_insn_i), .fetch_pc_i(fetch_pc_i),
    .fetch_ready_o(fetch_ready_o),
    .issue_valid_o(issue_valid_o), .issue_insn_o(issue_insn_o), .issue_pc_o(issue_pc_o),
    .issue_ready_i(issue_ready_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_mask_o(busy_mask_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit reads1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction
  function automatic bit reads2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit writes(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                      7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    for (int i = 0; i < 32; i++) m[i] = m_busy[i];
    return m;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, advance both.
  task automatic cyc(input bit fv, input logic [31:0] insn, input logic [31:0] pc,
                     input bit ir, input bit wv, input int wr, input bit fl);
    bit eff [32];
    bit hz, ev, fire, fr;
    int rs1, rs2, rd;
    logic [6:0] op;
    fetch_valid_i = fv; fetch_insn_i = insn; fetch_pc_i = pc;
    issue_ready_i = ir; wb_valid_i = wv; wb_rd_i = 5'(wr); flush_i = fl;
    #2;
    for (int i = 0; i < 32; i++) eff[i] = m_busy[i] && !(wv && wr == i) && i != 0;
    op = m_insn[6:0]; rs1 = int'(m_insn[19:15]); rs2 = int'(m_insn[24:20]); rd = int'(m_insn[11:7]);
    hz = m_hold && ((reads1(op) && eff[rs1]) || (reads2(op) && eff[rs2]) ||
                    (writes(op) && rd != 0 && eff[rd]));
    ev   = m_hold && !hz;
    fire = ev && ir;
    fr   = !fl && (!m_hold || fire);
    check("issue_valid", 32'(issue_valid_o), 32'(ev));
    check("stall",       32'(stall_o),       32'(m_hold && hz));
    check("fetch_ready", 32'(fetch_ready_o), 32'(fr));
    check("busy_mask",   busy_mask_o,        model_mask());
    check("issue_insn",  issue_insn_o,       m_insn);
    check("issue_pc",    issue_pc_o,         m_pc);
    for (int i = 0; i < 32; i++) m_busy[i] = eff[i];
    if (fire && writes(op) && rd != 0) m_busy[rd] = 1'b1;
    if (fl) m_hold = 1'b0;
    else if (fv && fr) begin m_hold = 1'b1; m_insn = insn; m_pc = pc; end
    else if (fire) m_hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ir);
    cyc(1'b0, 32'hDEAD_BEEF, 32'h0, ir, 1'b0, 0, 1'b0);
  endtask

  task automatic wb(input int r);
    cyc(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1, r, 1'b0);
  endtask

  initial begin
    logic [6:0] ops [11];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b1111111};

    // 1. Reset held two cycles with fetch and flush active
    rst = 1'b1; fetch_valid_i = 1'b1; fetch_insn_i = 32'h0020_0113; fetch_pc_i = 32'h200;
    issue_ready_i = 1'b1; wb_valid_i = 1'b0; wb_rd_i = 5'd0; flush_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    check("rst_stall",       32'(stall_o),       32'd0);
    check("rst_pc",          issue_pc_o,         BASE);
    check("rst_insn",        issue_insn_o,       NOP);
    check("rst_busy",        busy_mask_o,        32'd0);
    rst = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0;
    m_hold = 1'b0; m_insn = NOP; m_pc = BASE;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    #1;
    check("rel_fetch_ready", 32'(fetch_ready_o), 32'd1);

    // 2. Back-to-back independent addi x1 / addi x2
    cyc(1'b1, 32'h0010_0093, 32'h100, 1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'h0020_0113, 32'h104, 1'b1, 1'b0, 0, 1'b0);
    check("b2b_busy1", busy_mask_o, 32'h2);
    idle(1'b1);
    check("b2b_busy2", busy_mask_o, 32'h6);
    wb(1); wb(2);

    // 3. RAW stall released by same-cycle writeback
    cyc(1'b1, 32'h0000_0293, 32'h108, 1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'h0002_8333, 32'h10C, 1'b1, 1'b0, 0, 1'b0);
    check("raw_stall", 32'(stall_o), 32'd1);
    cyc(1'b1, 32'h0000_0013, 32'h110, 1'b1, 1'b0, 0, 1'b0);
    check("raw_hold_pc", issue_pc_o, 32'h10C);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5, 1'b0);
    check("raw_busy", busy_mask_o, 32'h40);
    wb(6);

    // 4. x0 destination never marks busy
    cyc(1'b1, 32'h0000_0013, 32'h114, 1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'h0000_00B3, 32'h118, 1'b1, 1'b1, 0, 1'b0);
    check("x0_busy", busy_mask_o, 32'h0);
    idle(1'b1);
    wb(1);

    // 5. Backpressure, then flush during a stall
    cyc(1'b1, 32'h0000_0193, 32'h11C, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0040_0213, 32'h120, 1'b0, 1'b0, 0, 1'b0);
    check("bp_hold_insn", issue_insn_o, 32'h0000_0193);
    cyc(1'b1, 32'h0001_8233, 32'h124, 1'b1, 1'b0, 0, 1'b0);
    idle(1'b1);
    cyc(1'b1, 32'h0000_0013, 32'h128, 1'b1, 1'b0, 0, 1'b1);
    check("flush_busy", busy_mask_o, 32'h8);
    idle(1'b1);
    wb(3);

    // 6. Same-cycle set and clear of x7
    cyc(1'b1, 32'h0000_0393, 32'h12C, 1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'h0010_0393, 32'h130, 1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 7, 1'b0);
    check("setclr_busy", busy_mask_o, 32'h80);
    wb(7);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri;
      ri = mk(ops[$urandom_range(0, 10)], $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
      cyc(1'($urandom_range(0, 3) != 0), ri, $urandom,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7), 1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Issue controller between fetch and the decode/execute datapath of the RV32I pipeline. It buffers one fetched instruction and tracks which registers have writes in flight using a 32-bit scoreboard. It stalls issue on read-after-write and write-after-write hazards until writeback clears the register. It also handles backpressure from downstream and pipeline flushes.

Parameters:
DWIDTH, 32, instruction/data width
AWIDTH, 32, PC width
BASEADDR, 32'h0100_0000, PC value presented during reset/empty

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
fetch_valid_i  input  1  fetch offers an instruction
fetch_insn_i  input  DWIDTH  fetched instruction
fetch_pc_i  input  AWIDTH  PC of fetched instruction
fetch_ready_o  output  1  controller accepts fetch this cycle
issue_valid_o  output  1  held instruction is hazard-free and offered downstream
issue_insn_o  output  DWIDTH  held instruction
issue_pc_o  output  AWIDTH  held PC
issue_ready_i  input  1  decode/execute accepts issue
wb_valid_i  input  1  writeback retiring a register write
wb_rd_i  input  5  register being written back
flush_i  input  1  discard held instruction (branch/jump redirect)
stall_o  output  1  held instruction blocked by hazard
busy_mask_o  output  32  scoreboard, bit n = write to xn in flight

Behaviour:
- Reset: hold_valid=0, busy=0. Outputs: issue_valid_o=0, stall_o=0, busy_mask_o=0, issue_pc_o=BASEADDR, issue_insn_o=32'h0000_0013 (NOP). Reset overrides flush and all other inputs.
- States are derived from hold_valid and hazard:
  - EMPTY: no instruction held.
  - READY: instruction held, no hazard.
  - STALL: instruction held, hazard present.
- Per-opcode field usage, decoded from insn[6:0]:
  - rs1 read: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111.
  - rs2 read: R, STORE, BRANCH.
  - rd write: R, OP-IMM, LOAD, JAL 1101111, JALR, LUI 0110111, AUIPC 0010111.
  - SYSTEM 1110011 and unknown opcodes: no reads, no writes.
  - rs1=insn[19:15], rs2=insn[24:20], rd=insn[11:7].
- Effective busy: eff_busy = busy & ~(wb_valid_i ? onehot(wb_rd_i) : 0). This bypasses writeback in the same cycle. Bit 0 is always 0.
- Hazard: hold_valid AND any of:
  - rs1 read and eff_busy[rs1]
  - rs2 read and eff_busy[rs2]
  - rd write and rd!=0 and eff_busy[rd] (WAW)
- Combinational outputs:
  - issue_valid_o = hold_valid & ~hazard
  - stall_o = hold_valid & hazard
- Issue fire = issue_valid_o & issue_ready_i.
- fetch_ready_o = ~flush_i & (~hold_valid | fire).
- Accept = fetch_valid_i & fetch_ready_o. On accept, the hold register loads insn/pc at the clock edge. This allows back-to-back issue: one instruction per cycle with zero bubbles.
- Hold register update on clock edge, in priority order:
  - flush_i: hold_valid←0.
  - accept: load, hold_valid←1.
  - fire without accept: hold_valid←0.
  - otherwise: hold.
- When hold_valid=0, issue_insn_o and issue_pc_o keep their last value (BASEADDR/NOP after reset).
- Scoreboard update on clock edge:
  - busy_next = eff_busy.
  - On fire with an rd-writing opcode and rd!=0, set busy_next[rd].
  - Set wins over a same-cycle wb clear of the same register: a new writer is in flight.
  - wb_valid_i for a non-busy register or x0: no effect.
  - flush_i does NOT clear busy, because older in-flight writes still retire.
  - flush_i in the same cycle as fire: the fire completes (the scoreboard sets), then the hold is emptied.
- busy_mask_o is registered busy (pre-bypass).
- Latency: fetch accept to issue_valid_o is 1 cycle. A wb clearing a hazard releases issue in the same cycle.

Test Plan:
1. Reset: assert rst 2 cycles with fetch_valid_i=1 and flush_i=1 → issue_valid_o=0, issue_pc_o=32'h0100_0000, issue_insn_o=32'h0000_0013, busy_mask_o=0, fetch_ready_o=1 after release.
2. Back-to-back independent: addi x1,x0,1 (32'h0010_0093) then addi x2,x0,2 (32'h0020_0113), issue_ready_i=1 → issued on consecutive cycles; busy_mask_o goes 0x2 then 0x6.
3. RAW stall + bypass: issue addi x5, then add x6,x5,x0 (32'h0002_8333) → stall_o=1, fetch_ready_o=0. Pulse wb_valid_i with wb_rd_i=5 in cycle N → issue_valid_o=1 in cycle N. busy_mask_o after N: bit5=0, bit6=1.
4. x0 destination: addi x0,x0,0 issued; wb_valid_i with wb_rd_i=0 → busy_mask_o stays 0, and a following add x1,x0,x0 issues without stall.
5. Backpressure and flush: hold an instruction with issue_ready_i=0 for 3 cycles → fetch_ready_o=0 and hold stable. Then assert flush_i during STALL → next cycle issue_valid_o=0, stall_o=0, busy_mask_o unchanged.
6. Same-cycle set/clear: x7 busy; issue a new writer to x7 while wb_valid_i clears x7 → busy_mask_o bit7 remains 1.
